// File: rtl/vga_sync_decoder.sv
// Receive-side VGA timing decoder: recovers pixel coordinates from hsync/vsync/bright,
// measures line and frame periods, and tracks lock against the expected mode.
module vga_sync_decoder #(
   parameter int H_TOTAL     = 800,
   parameter int V_TOTAL     = 521,
   parameter int LOCK_FRAMES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        hsync,
   input  logic        vsync,
   input  logic        bright,
   output logic [9:0]  x,
   output logic [9:0]  y,
   output logic        pixel_valid,
   output logic        line_start,
   output logic        frame_start,
   output logic        locked,
   output logic        sync_err,
   output logic [10:0] h_total_meas,
   output logic [10:0] v_total_meas
);

   typedef enum logic [1:0] {SEARCH, TRAIN, LOCKED} state_t;

   function automatic logic [10:0] sat_inc11(input logic [10:0] v);
      return (v == 11'h7FF) ? v : v + 11'd1;
   endfunction

   function automatic logic [9:0] sat_inc10(input logic [9:0] v);
      return (v == 10'h3FF) ? v : v + 10'd1;
   endfunction

   logic        hsync_p0, vsync_p0, bright_p0;
   logic        hsync_p1, vsync_p1, bright_p1;
   logic [10:0] hcnt, lcnt;
   logic [9:0]  xcnt, ycnt;
   logic        h_seen, line_bad;
   logic        ev_line_bad_p1, ev_sat_p1, ev_frame_p1, ev_match_p1;
   state_t      state, state_next;
   logic [2:0]  good_frames, good_frames_next;
   logic        err_next;

   logic        h_fall, v_fall, b_fall, h_sat, h_bad, frame_match;
   logic [10:0] h_len;
   logic [9:0]  x_base;

   // Stage p0/p1: input capture and one-cycle-delayed copy for edge detection.
   always_ff @(posedge clk) begin
      if (rst) begin
         hsync_p0  <= 1'b0;
         vsync_p0  <= 1'b0;
         bright_p0 <= 1'b0;
         hsync_p1  <= 1'b0;
         vsync_p1  <= 1'b0;
         bright_p1 <= 1'b0;
      end else begin
         hsync_p0  <= hsync;
         vsync_p0  <= vsync;
         bright_p0 <= bright;
         hsync_p1  <= hsync_p0;
         vsync_p1  <= vsync_p0;
         bright_p1 <= bright_p0;
      end
   end

   always_comb begin
      h_fall      = hsync_p1 & ~hsync_p0;
      v_fall      = vsync_p1 & ~vsync_p0;
      b_fall      = bright_p1 & ~bright_p0;
      h_sat       = (hcnt == 11'h7FF);
      h_len       = sat_inc11(hcnt);
      h_bad       = h_fall & h_seen & (h_len != 11'(H_TOTAL));
      // The line closing at a coincident hsync/vsync fall still belongs to the old frame.
      frame_match = ~line_bad & ~h_bad & ~h_sat & (lcnt == 11'(V_TOTAL));
      x_base      = h_fall ? 10'd0 : xcnt;
   end

   // Stage p1 -> outputs: counters, coordinates, measurements and FSM events.
   always_ff @(posedge clk) begin
      if (rst) begin
         hcnt           <= '0;
         lcnt           <= '0;
         xcnt           <= '0;
         ycnt           <= '0;
         h_seen         <= 1'b0;
         line_bad       <= 1'b0;
         x              <= '0;
         y              <= '0;
         pixel_valid    <= 1'b0;
         line_start     <= 1'b0;
         frame_start    <= 1'b0;
         h_total_meas   <= '0;
         v_total_meas   <= '0;
         ev_line_bad_p1 <= 1'b0;
         ev_sat_p1      <= 1'b0;
         ev_frame_p1    <= 1'b0;
         ev_match_p1    <= 1'b0;
      end else begin
         hcnt <= h_fall ? 11'd0 : sat_inc11(hcnt);
         if (h_fall) begin
            h_seen <= 1'b1;
            if (h_seen) h_total_meas <= h_len;
         end
         if (v_fall) begin
            v_total_meas <= lcnt;
            lcnt         <= h_fall ? 11'd1 : 11'd0;
         end else if (h_fall) begin
            lcnt <= sat_inc11(lcnt);
         end
         if (v_fall)             line_bad <= 1'b0;
         else if (h_bad | h_sat) line_bad <= 1'b1;
         xcnt <= bright_p0 ? sat_inc10(x_base) : x_base;
         x    <= x_base;
         if (v_fall)      ycnt <= '0;
         else if (b_fall) ycnt <= sat_inc10(ycnt);
         y              <= v_fall ? 10'd0 : ycnt;
         pixel_valid    <= bright_p0;
         line_start     <= h_fall;
         frame_start    <= v_fall;
         ev_line_bad_p1 <= h_bad;
         ev_sat_p1      <= h_sat;
         ev_frame_p1    <= v_fall;
         ev_match_p1    <= frame_match;
      end
   end

   always_comb begin
      state_next       = state;
      good_frames_next = good_frames;
      err_next         = 1'b0;
      case (state)
         SEARCH: begin
            if (ev_frame_p1) begin
               state_next       = TRAIN;
               good_frames_next = '0;
            end
         end
         TRAIN: begin
            if (ev_frame_p1) begin
               if (!ev_match_p1) begin
                  good_frames_next = '0;
               end else if (({1'b0, good_frames} + 4'd1) >= 4'(LOCK_FRAMES)) begin
                  state_next       = LOCKED;
                  good_frames_next = '0;
               end else begin
                  good_frames_next = good_frames + 3'd1;
               end
            end
         end
         LOCKED: begin
            if (ev_line_bad_p1 | ev_sat_p1 | (ev_frame_p1 & ~ev_match_p1)) begin
               err_next         = 1'b1;
               state_next       = SEARCH;
               good_frames_next = '0;
            end
         end
         default: state_next = SEARCH;
      endcase
   end

   // Stage p2: lock state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= SEARCH;
         good_frames <= '0;
         sync_err    <= 1'b0;
      end else begin
         state       <= state_next;
         good_frames <= good_frames_next;
         sync_err    <= err_next;
      end
   end

   assign locked = (state == LOCKED);

endmodule
